// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle CPU memory port: FSM encoding,
// default timeout and word-alignment helpers.
package mc_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  function automatic logic isAligned(input logic [31:0] addr);
    return (addr & WORD_ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit wait counter for a memory access; flags expiry once it has counted
// TIMEOUT-1 cycles since the last clear.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] countReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      countReg <= 8'd0;
    else if (clr)
      countReg <= 8'd0;
    else if (en)
      countReg <= countReg + 8'd1;
  end

  assign expired = (countReg == LAST);

endmodule

// File: rtl/mc_mem_port.sv
// Memory port for a multi-cycle CPU: one access per request, word-aligned,
// with timeout, loading IR or MDR on read completion.
module mc_mem_port
  import mc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        iord,
  input  logic        ld_ir,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  stateReg;
  logic [1:0]  stateNext;
  logic        ldIrReg;
  logic        expired;
  logic        inAccess;
  logic        accept;
  logic [31:0] reqAddr;

  assign reqAddr  = iord ? alu_out : pc;
  assign inAccess = (stateReg == ST_ACCESS);
  assign accept   = (stateReg == ST_IDLE) && cpu_req && isAligned(reqAddr);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!inAccess),
    .en     (inAccess),
    .expired(expired)
  );

  // Ack takes priority over an expiry in the same cycle.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE: begin
        if (cpu_req)
          stateNext = isAligned(reqAddr) ? ST_ACCESS : ST_ERR;
      end
      ST_ACCESS: begin
        if (mem_ack)
          stateNext = ST_DONE;
        else if (expired)
          stateNext = ST_ERR;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      done     <= (stateNext == ST_DONE) || (stateNext == ST_ERR);
      err      <= (stateNext == ST_ERR);
      busy     <= (stateNext != ST_IDLE);
      mem_req  <= (stateNext == ST_ACCESS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      ldIrReg   <= 1'b0;
    end else if (accept) begin
      mem_we    <= cpu_we;
      mem_addr  <= reqAddr;
      mem_wdata <= wdata;
      ldIrReg   <= ld_ir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir  <= 32'h0;
      mdr <= 32'h0;
    end else if (inAccess && mem_ack && !mem_we) begin
      if (ldIrReg)
        ir <= mem_rdata;
      else
        mdr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed bench for mc_mem_port (TIMEOUT=4): vector table plus hand-written
// reset, back-to-back and ignored-request sequences.
module tb_mc_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, iord, ld_ir;
  logic [31:0] pc, alu_out, wdata;
  logic        done, err, busy;
  logic [31:0] ir, mdr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mc_mem_port #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .iord(iord),
    .ld_ir(ld_ir), .pc(pc), .alu_out(alu_out), .wdata(wdata), .done(done),
    .err(err), .busy(busy), .ir(ir), .mdr(mdr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we, iordSel, ldIr;
    logic [31:0] pcVal, aluVal, wdataVal, rdataVal;
    int          ackAt;      // 0 = never ack
    logic        expErr;
    logic [31:0] expAddr, expIr, expMdr;
    int          expLat, expReq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int   cyc;
    int   reqCycles;
    logic heldOk;
    cyc = 0;
    reqCycles = 0;
    heldOk = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; iord = v.iordSel; ld_ir = v.ldIr;
    pc = v.pcVal; alu_out = v.aluVal; wdata = v.wdataVal; mem_rdata = v.rdataVal;
    @(negedge clk);
    cpu_req = 1'b0;
    while (!done && cyc < 20) begin
      if (mem_req) begin
        reqCycles++;
        if (mem_addr !== v.expAddr || mem_we !== v.we || busy !== 1'b1) heldOk = 1'b0;
        if (v.we && mem_wdata !== v.wdataVal) heldOk = 1'b0;
      end
      mem_ack = (v.ackAt == cyc + 1);
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
    end
    check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_err", idx), 32'(err), 32'(v.expErr));
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.expLat));
    check($sformatf("v%0d_reqCycles", idx), 32'(reqCycles), 32'(v.expReq));
    check($sformatf("v%0d_held", idx), 32'(heldOk), 32'd1);
    check($sformatf("v%0d_memReqLow", idx), 32'(mem_req), 32'd0);
    check($sformatf("v%0d_ir", idx), ir, v.expIr);
    check($sformatf("v%0d_mdr", idx), mdr, v.expMdr);
    @(negedge clk);
    check($sformatf("v%0d_donePulse", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_idleBusy", idx), 32'(busy), 32'd0);
    $display("[TB] txn %0d we=%0b iord=%0b lat=%0d req=%0d err=%0b ir=%h mdr=%h",
             idx, v.we, v.iordSel, cyc, reqCycles, v.expErr, ir, mdr);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'h8C220004, 3,
                1'b0, 32'h40, 32'h8C220004, 32'h0, 3, 3};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 32'hDEADBEEF, 1,
                1'b0, 32'h104, 32'h8C220004, 32'hDEADBEEF, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h200, 32'h12345678, 32'hFFFFFFFF, 2,
                1'b0, 32'h200, 32'h8C220004, 32'hDEADBEEF, 2, 2};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0, 32'h0, 1,
                1'b1, 32'h0, 32'h8C220004, 32'hDEADBEEF, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h41, 32'h0, 32'h0, 32'h0, 1,
                1'b1, 32'h0, 32'h8C220004, 32'hDEADBEEF, 0, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h3, 32'h400, 32'hA5A5A5A5, 32'h0, 1,
                1'b0, 32'h400, 32'h8C220004, 32'hDEADBEEF, 1, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h55555555, 0,
                1'b1, 32'h80, 32'h8C220004, 32'hDEADBEEF, 4, 4};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h84, 32'h0, 32'h0, 32'hCAFEF00D, 4,
                1'b0, 32'h84, 32'hCAFEF00D, 32'hDEADBEEF, 4, 4};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0BADF00D, 2,
                1'b0, 32'h300, 32'hCAFEF00D, 32'h0BADF00D, 2, 2};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; iord = 1'b0; ld_ir = 1'b0;
    pc = 32'h0; alu_out = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memReq", 32'(mem_req), 32'd0);
    check("rst_memWe", 32'(mem_we), 32'd0);
    check("rst_memAddr", mem_addr, 32'h0);
    check("rst_memWdata", mem_wdata, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) runVec(i, vecs[i]);

    // Back-to-back: cpu_req held high; changes during ACCESS/DONE ignored
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; iord = 1'b0; ld_ir = 1'b0; pc = 32'h20;
    @(negedge clk);
    check("b2b_req1", 32'(mem_req), 32'd1);
    pc = 32'h24; mem_ack = 1'b1; mem_rdata = 32'h11111111;
    check("b2b_addrHeld", mem_addr, 32'h20);
    @(negedge clk);
    mem_ack = 1'b0;
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_mdr1", mdr, 32'h11111111);
    @(negedge clk);
    check("b2b_idleBusy", 32'(busy), 32'd0);
    check("b2b_idleReq", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("b2b_req2", 32'(mem_req), 32'd1);
    check("b2b_addr2", mem_addr, 32'h24);
    cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_ack = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_mdr2", mdr, 32'h22222222);
    $display("[TB] txn b2b mdr=%h", mdr);

    // Reset in the middle of an access
    @(negedge clk);
    cpu_req = 1'b1; iord = 1'b0; ld_ir = 1'b1; pc = 32'h10;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("midRst_reqBefore", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midRst_memReq", 32'(mem_req), 32'd0);
    check("midRst_busy", 32'(busy), 32'd0);
    check("midRst_ir", ir, 32'h0);
    check("midRst_mdr", mdr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midRst_noDone%0d", c), 32'(done), 32'd0);
      check($sformatf("midRst_irKeep%0d", c), ir, 32'h0);
    end
    mem_ack = 1'b0;
    $display("[TB] txn midReset busy=%0b ir=%h", busy, ir);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
